// File: rtl/rr_prior_encoder.sv
// Registered priority encoder with fixed-priority or round-robin search.
// Grants are held until acknowledged; round-robin rotates without bubbles via a pointer bypass.
module rr_prior_encoder #(
  parameter int Width = 8,
  localparam int IdxW = $clog2(Width)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Width-1:0] in,
  input  logic            enable,
  input  logic            mode,
  input  logic            ack,
  output logic [IdxW-1:0] out,
  output logic [Width-1:0] out_onehot,
  output logic            out_valid
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

  logic [IdxW-1:0]  out_q, out_d;
  logic [Width-1:0] out_onehot_q, out_onehot_d;
  logic             out_valid_q, out_valid_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;

  logic             accept;
  logic [IdxW-1:0]  ptr_eff;
  logic             hi_found;
  logic [IdxW-1:0]  hi_idx, lo_idx, fix_idx, sel;

  always_comb begin
    accept = out_valid_q & ack;
    // Bypass the pointer on an accept so the next search already starts past the accepted grant.
    if (accept && mode) begin
      ptr_eff = (out_q == LastIdx) ? '0 : out_q + IdxW'(1);
    end else begin
      ptr_eff = ptr_q;
    end

    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in[i]) begin
        lo_idx = IdxW'(i);
        if (i >= int'(ptr_eff)) begin
          hi_found = 1'b1;
          hi_idx   = IdxW'(i);
        end
      end
    end

    fix_idx = '0;
    for (int i = 0; i < Width; i++) begin
      if (in[i]) fix_idx = IdxW'(i);
    end

    sel = mode ? (hi_found ? hi_idx : lo_idx) : fix_idx;

    out_d        = out_q;
    out_onehot_d = out_onehot_q;
    out_valid_d  = out_valid_q;
    ptr_d        = ptr_q;

    if (!enable) begin
      out_d        = '0;
      out_onehot_d = '0;
      out_valid_d  = 1'b0;
    end else if (out_valid_q && !ack) begin
      out_d        = out_q;
    end else begin
      if (accept && mode) ptr_d = ptr_eff;
      if (in == '0) begin
        out_d        = '0;
        out_onehot_d = '0;
        out_valid_d  = 1'b0;
      end else begin
        out_d       = sel;
        out_valid_d = 1'b1;
        for (int i = 0; i < Width; i++) begin
          out_onehot_d[i] = (sel == IdxW'(i));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_onehot_q <= '0;
      out_valid_q  <= 1'b0;
      ptr_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_onehot_q <= out_onehot_d;
      out_valid_q  <= out_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out        = out_q;
  assign out_onehot = out_onehot_q;
  assign out_valid  = out_valid_q;

endmodule

// File: doc/rr_prior_encoder.md
# rr_prior_encoder

Parametrised, registered priority encoder with a selectable fixed-priority or round-robin search and a grant/acknowledge handshake. It is the sequential successor to the combinational enable-gated priority encoder. It sits between a bank of level-sensitive request lines and a single consumer, such as a shared-resource arbiter or an interrupt dispatcher. Grants are held stable until acknowledged, and round-robin mode guarantees fairness across requesters.

## Interface
- Width, 8, number of request lines; legal range 2..256, not required to be a power of two
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- in  input  Width  level-sensitive request vector; bit i = requester i
- enable  input  1  global enable; 0 suppresses and drops all grants
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin
- ack  input  1  consumer accepts current grant; sampled only when out_valid=1
- out  output  $clog2(Width)  registered index of the granted request
- out_onehot  output  Width  registered one-hot form of out; all zero when out_valid=0
- out_valid  output  1  grant present

## Operation
- State: output registers (out, out_onehot, out_valid) and round-robin pointer ptr, which is $clog2(Width) bits wide with range 0..Width-1.
- Accept event: out_valid=1 and ack=1 at a rising edge.
- Next-grant logic is evaluated at each rising edge in the following priority order:
  1. enable=0: out_valid<=0, out<=0, out_onehot<=0. ptr is unchanged.
  2. out_valid=1 and ack=0: hold. out and out_onehot keep their values, even if `in` changes or the granted bit drops. mode changes are ignored until the next new grant.
  3. Otherwise, a new search runs:
     - If in==0: out_valid<=0, out<=0, out_onehot<=0.
     - If mode=0: out<=index of the highest set bit of `in`.
     - If mode=1: out<=first set bit at index >= ptr_eff, searching in ascending order. If no set bit exists at or above ptr_eff, the search wraps and grants the lowest set bit.
     - In both cases, out_valid<=1 and out_onehot<=1<<out.
- ptr_eff is the pointer used for the search:
  - On an accept event in mode=1: ptr_eff = (out==Width-1) ? 0 : out+1.
  - Otherwise: ptr_eff = ptr.
- ptr update: on an accept event with mode=1, ptr<=ptr_eff. Accepts in mode=0 leave ptr unchanged.
- ack while out_valid=0 is ignored.
- Wrap-around: the pointer and the search wrap at Width-1 to 0. For non-power-of-two Width, indices >= Width never appear on out or ptr.
- Reset (asynchronous, any time, including mid-hold): out=0, out_onehot=0, out_valid=0, ptr=0 immediately. All outputs stay at those values while rst=1. The first grant appears at the first rising edge after rst deasserts.

## Timing
- Latency: a request is sampled at edge N and its grant is visible after edge N, i.e. one cycle.
- Back-to-back: with ack held at 1, a new grant is issued every cycle. The pointer bypass (ptr_eff) ensures consecutive round-robin grants rotate without a bubble.
- Hold: a grant stays stable for as long as ack=0 and enable=1.
- Simultaneous events: enable=0 with ack=1 leaves ptr unchanged and drops the grant. Reset overrides everything.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset: assert rst mid-cycle → out=0, out_onehot=8'h00, out_valid=0 immediately. Release rst with in=0 → outputs stay 0.
- Fixed priority: mode=0, enable=1, ack=1, in=8'b00101100 → from the next cycle, out=5, out_onehot=8'b00100000, out_valid=1, repeating 5 every cycle. Change in to 8'b00000001 → out=0 with out_valid=1 next cycle.
- Round-robin rotation: start from reset, mode=1, enable=1, ack=1, in=8'b00101100 → grant sequence 2,3,5,2,3,5,… with no idle cycle. Setting in=8'hFF → 0,1,…,7,0.
- Hold and handshake: mode=1, obtain grant out=2, then ack=0 for 3 cycles while in changes to 8'b10000000 → out stays 2 and out_valid=1 throughout. Set ack=1 → next cycle out=7.
- Enable low: mode=1, in=8'hFF, grant out=4 held, enable=0 with ack=1 → next cycle out_valid=0, out=0. Re-enable → next grant is 4 because ptr did not advance.
- Mid-stream reset and non-power-of-two width (Width=5): in=5'b10011, mode=1, ack=1 → 0,1,4,0. Assert rst after grant 1 → outputs clear immediately. After release, grants restart at 0; out never exceeds 4.
